// File: rtl/inst_sram_pkg.sv
// Shared types and constants for the instruction SRAM responder.
package inst_sram_pkg;

  localparam int unsigned INST_W = 32;
  localparam int unsigned BE_W   = 4;

  localparam logic [INST_W-1:0] RESET_INST_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic              valid;
    logic              err;
    logic [INST_W-1:0] pc;
    logic [INST_W-1:0] data;
  } resp_stage_t;

  // Advance one pipeline stage: err is qualified by valid, pc/data hold across bubbles.
  function automatic resp_stage_t stage_advance(resp_stage_t src, resp_stage_t cur);
    resp_stage_t nxt;
    nxt       = cur;
    nxt.valid = src.valid;
    nxt.err   = src.valid & src.err;
    if (src.valid) begin
      nxt.pc   = src.pc;
      nxt.data = src.data;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/inst_sram_if.sv
// Fetch request/response and load-port bundle between fetch (master) and the responder (slave).
interface inst_sram_if #(
  parameter int unsigned ADDR_WIDTH = 10
);
  import inst_sram_pkg::*;

  logic                  inst_sram_en;
  logic [INST_W-1:0]     pc;
  logic [INST_W-1:0]     inst_rdata;
  logic [INST_W-1:0]     inst_rpc;
  logic                  inst_valid;
  logic                  inst_err;
  logic                  ld_we;
  logic [ADDR_WIDTH-1:0] ld_addr;
  logic [INST_W-1:0]     ld_wdata;
  logic [BE_W-1:0]       ld_be;

  modport master (
    output inst_sram_en, pc, ld_we, ld_addr, ld_wdata, ld_be,
    input  inst_rdata, inst_rpc, inst_valid, inst_err
  );

  modport slave (
    input  inst_sram_en, pc, ld_we, ld_addr, ld_wdata, ld_be,
    output inst_rdata, inst_rpc, inst_valid, inst_err
  );

endinterface

// File: rtl/inst_sram_resp_rd_pipe.sv
// Fixed-length delay line of response stages; every stage clears asynchronously on rst.
module sram_rd_pipe
  import inst_sram_pkg::*;
#(
  parameter int unsigned       LATENCY    = 1,
  parameter logic [INST_W-1:0] RESET_INST = RESET_INST_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  resp_stage_t stage_i,
  output resp_stage_t stage_o
);

  localparam resp_stage_t RESET_STAGE = '{valid: 1'b0, err: 1'b0, pc: '0, data: RESET_INST};

  resp_stage_t stage_q [LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LATENCY; i++) stage_q[i] <= RESET_STAGE;
    end else begin
      stage_q[0] <= stage_advance(stage_i, stage_q[0]);
      for (int i = 1; i < LATENCY; i++) stage_q[i] <= stage_advance(stage_q[i-1], stage_q[i]);
    end
  end

  assign stage_o = stage_q[LATENCY-1];

endmodule

// File: rtl/inst_sram_resp.sv
// Instruction SRAM responder: byte-enabled load port, range-checked fetch, fixed-latency response.
module inst_sram_resp
  import inst_sram_pkg::*;
#(
  parameter int unsigned       ADDR_WIDTH = 10,
  parameter int unsigned       LATENCY    = 1,
  parameter logic [INST_W-1:0] RESET_INST = RESET_INST_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  inst_sram_if.slave   sram_if
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [INST_W-1:0]     mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic                  req_err;
  resp_stage_t           req_stage;
  resp_stage_t           out_stage;

  // Misaligned or beyond-array PCs are errored; the array read is bypassed for them.
  assign rd_idx  = sram_if.pc[ADDR_WIDTH+1:2];
  assign req_err = (sram_if.pc[1:0] != 2'b00) || (sram_if.pc[INST_W-1:ADDR_WIDTH+2] != '0);

  always_comb begin
    req_stage       = '0;
    req_stage.valid = sram_if.inst_sram_en;
    req_stage.err   = req_err;
    req_stage.pc    = sram_if.pc;
    req_stage.data  = req_err ? RESET_INST : mem_q[rd_idx];
  end

  // Asynchronous read feeding stage 0 makes a same-cycle load/fetch collision read-first.
  always_ff @(posedge clk) begin
    if (sram_if.ld_we) begin
      for (int b = 0; b < BE_W; b++) begin
        if (sram_if.ld_be[b]) mem_q[sram_if.ld_addr][8*b +: 8] <= sram_if.ld_wdata[8*b +: 8];
      end
    end
  end

  sram_rd_pipe #(
    .LATENCY    (LATENCY),
    .RESET_INST (RESET_INST)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .stage_i (req_stage),
    .stage_o (out_stage)
  );

  assign sram_if.inst_valid = out_stage.valid;
  assign sram_if.inst_err   = out_stage.err;
  assign sram_if.inst_rpc   = out_stage.pc;
  assign sram_if.inst_rdata = out_stage.data;

endmodule

// File: tb/tb_inst_sram_resp.sv
// Directed bench: LATENCY=1 instance for read/load/error/collision, LATENCY=3 instance for gaps and reset.
module tb_inst_sram_resp;

  localparam logic [31:0] RI3 = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst1 = 1'b1;
  logic rst3 = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  inst_sram_if #(.ADDR_WIDTH(10)) if1 ();
  inst_sram_if #(.ADDR_WIDTH(10)) if3 ();

  inst_sram_resp #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst1), .sram_if(if1)
  );
  inst_sram_resp #(.ADDR_WIDTH(10), .LATENCY(3), .RESET_INST(RI3)) dut3 (
    .clk(clk), .rst(rst3), .sram_if(if3)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge with the write landed.
  task automatic ld1(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
    if1.ld_we = 1'b1; if1.ld_addr = a; if1.ld_wdata = d; if1.ld_be = be;
    @(negedge clk);
    if1.ld_we = 1'b0;
  endtask

  task automatic ld3(input logic [9:0] a, input logic [31:0] d);
    if3.ld_we = 1'b1; if3.ld_addr = a; if3.ld_wdata = d; if3.ld_be = 4'hF;
    @(negedge clk);
    if3.ld_we = 1'b0;
  endtask

  // LATENCY=1: on return the response of this fetch is on the outputs.
  task automatic fetch1(input logic [31:0] p);
    if1.inst_sram_en = 1'b1; if1.pc = p;
    @(negedge clk);
    if1.inst_sram_en = 1'b0;
  endtask

  logic [31:0] w1 [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
  logic [31:0] w3 [4] = '{32'hA1A1A1A1, 32'hB2B2B2B2, 32'hC3C3C3C3, 32'hD4D4D4D4};
  logic        en_pat [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  logic [31:0] pc_pat [4] = '{32'h0, 32'h0, 32'h4, 32'h8};

  initial begin
    if1.inst_sram_en = 1'b0; if1.pc = '0; if1.ld_we = 1'b0; if1.ld_addr = '0;
    if1.ld_wdata = '0; if1.ld_be = '0;
    if3.inst_sram_en = 1'b0; if3.pc = '0; if3.ld_we = 1'b0; if3.ld_addr = '0;
    if3.ld_wdata = '0; if3.ld_be = '0;

    repeat (2) @(negedge clk);
    check("rst1_valid", 32'(if1.inst_valid), 32'h0);
    check("rst1_err",   32'(if1.inst_err),   32'h0);
    check("rst1_rdata", if1.inst_rdata,      32'h0);
    check("rst1_rpc",   if1.inst_rpc,        32'h0);
    check("rst3_valid", 32'(if3.inst_valid), 32'h0);
    check("rst3_rdata", if3.inst_rdata,      RI3);
    rst1 = 1'b0;
    rst3 = 1'b0;

    // Back-to-back reads at LATENCY=1
    for (int i = 0; i < 4; i++) ld1(10'(i), w1[i], 4'hF);
    for (int i = 0; i < 4; i++) begin
      if1.inst_sram_en = 1'b1; if1.pc = 32'(4 * i);
      @(negedge clk);
      check("b2b_valid", 32'(if1.inst_valid), 32'h1);
      check("b2b_rdata", if1.inst_rdata, w1[i]);
      check("b2b_rpc",   if1.inst_rpc,   32'(4 * i));
    end
    if1.inst_sram_en = 1'b0;
    @(negedge clk);
    check("idle_valid", 32'(if1.inst_valid), 32'h0);
    check("idle_err",   32'(if1.inst_err),   32'h0);
    check("idle_rdata", if1.inst_rdata, 32'h44444444);
    check("idle_rpc",   if1.inst_rpc,   32'hC);

    // Byte enables, including an all-zero mask
    ld1(10'd5, 32'hAABBCCDD, 4'hF);
    ld1(10'd5, 32'h00001200, 4'b0010);
    fetch1(32'h14);
    check("be_rdata", if1.inst_rdata, 32'hAABB12DD);
    ld1(10'd5, 32'hFFFFFFFF, 4'h0);
    fetch1(32'h14);
    check("be0_rdata", if1.inst_rdata, 32'hAABB12DD);

    // Error conditions and top-of-array boundary
    fetch1(32'h6);
    check("mis_valid", 32'(if1.inst_valid), 32'h1);
    check("mis_err",   32'(if1.inst_err),   32'h1);
    check("mis_rdata", if1.inst_rdata,      32'h0);
    check("mis_rpc",   if1.inst_rpc,        32'h6);
    fetch1(32'h1000);
    check("oor_err", 32'(if1.inst_err), 32'h1);
    ld1(10'h3FF, 32'hCAFEF00D, 4'hF);
    fetch1(32'hFFC);
    check("top_err",   32'(if1.inst_err), 32'h0);
    check("top_rdata", if1.inst_rdata,    32'hCAFEF00D);
    fetch1(32'hFFFFFFFC);
    check("wrap_err",   32'(if1.inst_err), 32'h1);
    check("wrap_rdata", if1.inst_rdata,    32'h0);

    // Same-cycle load and fetch of word 2: read-first
    ld1(10'd2, 32'h12345678, 4'hF);
    if1.ld_we = 1'b1; if1.ld_addr = 10'd2; if1.ld_wdata = 32'h55555555; if1.ld_be = 4'hF;
    if1.inst_sram_en = 1'b1; if1.pc = 32'h8;
    @(negedge clk);
    if1.ld_we = 1'b0; if1.inst_sram_en = 1'b0;
    check("coll_old", if1.inst_rdata, 32'h12345678);
    fetch1(32'h8);
    check("coll_new", if1.inst_rdata, 32'h55555555);

    // Gapped requests at LATENCY=3: driven in cycle j, visible at cycle j+2
    for (int i = 0; i < 4; i++) ld3(10'(i), w3[i]);
    for (int c = 0; c < 7; c++) begin
      if3.inst_sram_en = (c < 4) ? en_pat[c] : 1'b0;
      if3.pc           = (c < 4) ? pc_pat[c] : 32'h0;
      @(negedge clk);
      if (c < 2) begin
        check("gap_lead_valid", 32'(if3.inst_valid), 32'h0);
      end else if (c - 2 < 4) begin
        check("gap_valid", 32'(if3.inst_valid), 32'(en_pat[c-2]));
        if (en_pat[c-2]) begin
          check("gap_rdata", if3.inst_rdata, w3[pc_pat[c-2][3:2]]);
          check("gap_rpc",   if3.inst_rpc,   pc_pat[c-2]);
        end
      end else begin
        check("gap_tail_valid", 32'(if3.inst_valid), 32'h0);
      end
    end

    // Asynchronous reset with requests in flight
    for (int i = 0; i < 3; i++) begin
      if3.inst_sram_en = 1'b1; if3.pc = 32'(4 * i);
      @(negedge clk);
    end
    if3.inst_sram_en = 1'b0;
    check("mid_pre_valid", 32'(if3.inst_valid), 32'h1);
    check("mid_pre_rdata", if3.inst_rdata, w3[0]);
    #2 rst3 = 1'b1;
    #1;
    check("mid_async_valid", 32'(if3.inst_valid), 32'h0);
    check("mid_async_rdata", if3.inst_rdata, RI3);
    check("mid_async_rpc",   if3.inst_rpc,   32'h0);
    @(negedge clk);
    rst3 = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_valid", 32'(if3.inst_valid), 32'h0);
    end
    check("post_rdata", if3.inst_rdata, RI3);
    check("post_rpc",   if3.inst_rpc,   32'h0);
    check("post_err",   32'(if3.inst_err), 32'h0);

    // First response after release comes from a new request
    if3.inst_sram_en = 1'b1; if3.pc = 32'hC;
    @(negedge clk);
    if3.inst_sram_en = 1'b0;
    @(negedge clk);
    check("new_early_valid", 32'(if3.inst_valid), 32'h0);
    @(negedge clk);
    check("new_valid", 32'(if3.inst_valid), 32'h1);
    check("new_rdata", if3.inst_rdata, w3[3]);
    check("new_rpc",   if3.inst_rpc,   32'hC);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
